// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encodings and the iteration count.
package md_sequencer_pkg;

   localparam int MD_OP_LEN = 4;
   localparam int MD_ITERS  = 32;

   typedef enum logic [MD_OP_LEN-1:0] {
      MD_OP_NONE  = 4'd0,
      MD_OP_MULT  = 4'd1,
      MD_OP_MULTU = 4'd2,
      MD_OP_DIV   = 4'd3,
      MD_OP_DIVU  = 4'd4,
      MD_OP_MTHI  = 4'd5,
      MD_OP_MTLO  = 4'd6,
      MD_OP_MFHI  = 4'd7,
      MD_OP_MFLO  = 4'd8
   } md_op_e;

   typedef enum logic [1:0] {
      MD_ST_IDLE = 2'd0,
      MD_ST_MUL  = 2'd1,
      MD_ST_DIV  = 2'd2,
      MD_ST_FIX  = 2'd3
   } md_state_e;

endpackage

// File: rtl/md_sequencer_iter_step.sv
// One radix-2 step of the iterative multiplier / restoring divider.
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {remainder, quotient / remaining dividend bits}.
module md_iter_step
   import md_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 mode_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   trial_rem;
   logic [WIDTH-1:0] diff;

   // Single shift-add (multiply) or shift-subtract (divide) step
   always_comb begin
      sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
      trial_rem = acc[2*WIDTH-1:WIDTH-1];
      // The shifted remainder is below 2*divisor, so the difference fits in WIDTH bits
      diff      = acc[2*WIDTH-2:WIDTH-1] - operand;
      acc_next  = acc;
      if (mode_div) begin
         if (trial_rem >= {1'b0, operand})
            acc_next = {diff, acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
         if (acc[0])
            acc_next = {sum, acc[WIDTH-1:1]};
         else
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO unit controller: accepts one HI/LO op at a time, runs a 32-step
// multiply/divide, applies sign fix-up and commits HI/LO.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 op_valid,
   input  logic [MD_OP_LEN-1:0] op,
   input  logic [WIDTH-1:0]     src0,
   input  logic [WIDTH-1:0]     src1,
   input  logic                 flush,
   output logic                 op_ready,
   output logic                 stall,
   output logic [WIDTH-1:0]     rd_data,
   output logic [WIDTH-1:0]     hi,
   output logic [WIDTH-1:0]     lo
);

   md_state_e            state, state_next;
   md_op_e               op_e;
   logic [5:0]           cnt;
   logic [2*WIDTH-1:0]   acc, acc_next, prod;
   logic [WIDTH-1:0]     operand, fix_hi, fix_lo;
   logic                 is_div, neg_res, rem_neg, div_zero;
   logic                 accept, start_mul, start_div, is_signed, commit;

   // Magnitude of a possibly signed operand; the most negative value maps to itself
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   assign op_e      = md_op_e'(op);
   assign op_ready  = (state == MD_ST_IDLE) && !flush;
   assign stall     = op_valid && !op_ready;
   assign accept    = op_valid && op_ready;
   assign start_mul = accept && (op_e == MD_OP_MULT || op_e == MD_OP_MULTU);
   assign start_div = accept && (op_e == MD_OP_DIV  || op_e == MD_OP_DIVU);
   assign is_signed = (op_e == MD_OP_MULT) || (op_e == MD_OP_DIV);
   assign commit    = (state == MD_ST_FIX) && !flush;

   md_iter_step #(.WIDTH(WIDTH)) u_step (
      .mode_div (state == MD_ST_DIV),
      .acc      (acc),
      .operand  (operand),
      .acc_next (acc_next)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= MD_ST_IDLE;
      else       state <= state_next;
   end

   // Next-state logic; flush always returns to IDLE
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = MD_ST_IDLE;
      end else begin
         unique case (state)
            MD_ST_IDLE: if (start_mul) state_next = MD_ST_MUL;
                        else if (start_div) state_next = MD_ST_DIV;
            MD_ST_MUL,
            MD_ST_DIV:  if (cnt == 6'(MD_ITERS - 1)) state_next = MD_ST_FIX;
            MD_ST_FIX:  state_next = MD_ST_IDLE;
            default:    state_next = MD_ST_IDLE;
         endcase
      end
   end

   // Sign fix-up of the raw magnitude result; divide-by-zero yields zero
   always_comb begin
      prod   = neg_res ? -acc : acc;
      fix_hi = '0;
      fix_lo = '0;
      if (!is_div) begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end else if (!div_zero) begin
         fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fix_hi = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   // Move-from reads HI/LO directly; zero unless the read is accepted
   always_comb begin
      rd_data = '0;
      if (accept && op_e == MD_OP_MFHI) rd_data = hi;
      if (accept && op_e == MD_OP_MFLO) rd_data = lo;
   end

   // Operand latches, iteration datapath and HI/LO registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         acc      <= '0;
         operand  <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         rem_neg  <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else if (accept) begin
         if (op_e == MD_OP_MTHI) hi <= src0;
         if (op_e == MD_OP_MTLO) lo <= src0;
         if (start_mul || start_div) begin
            cnt      <= '0;
            is_div   <= start_div;
            neg_res  <= is_signed && (src0[WIDTH-1] ^ src1[WIDTH-1]);
            rem_neg  <= is_signed && src0[WIDTH-1];
            div_zero <= (src1 == '0);
            // Multiply keeps the multiplier in acc; divide keeps the dividend there
            acc      <= {{WIDTH{1'b0}}, start_div ? mag(src0, is_signed) : mag(src1, is_signed)};
            operand  <= start_div ? mag(src1, is_signed) : mag(src0, is_signed);
         end
      end else if (state == MD_ST_MUL || state == MD_ST_DIV) begin
         acc <= acc_next;
         cnt <= cnt + 6'd1;
      end else if (commit) begin
         hi <= fix_hi;
         lo <= fix_lo;
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed and randomized bench for md_sequencer with a HI/LO scoreboard.
module tb_md_sequencer;
   import md_sequencer_pkg::*;

   logic                 clk, reset, op_valid, flush;
   logic [MD_OP_LEN-1:0] op;
   logic [31:0]          src0, src1;
   logic                 op_ready, stall;
   logic [31:0]          rd_data, hi, lo;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_hi_q[$];
   logic [31:0] exp_lo_q[$];

   md_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .op_valid (op_valid),
      .op       (op),
      .src0     (src0),
      .src1     (src1),
      .flush    (flush),
      .op_ready (op_ready),
      .stall    (stall),
      .rd_data  (rd_data),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Reference model built on native 64-bit arithmetic
   function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (o)
         MD_OP_MULT:  p = sa * sb;
         MD_OP_MULTU: p = {32'b0, a} * {32'b0, b};
         MD_OP_DIV:   if (b != 0) begin
                         q = sa / sb;
                         r = sa % sb;
                         p = {r[31:0], q[31:0]};
                      end
         MD_OP_DIVU:  if (b != 0) p = {a % b, a / b};
         default:     p = '0;
      endcase
      eh = p[63:32];
      el = p[31:0];
   endfunction

   task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int n;
      @(negedge clk);
      op_valid = 1'b1; op = o; src0 = a; src1 = b;
      exp_hi_q.push_back(eh);
      exp_lo_q.push_back(el);
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE;
      n = 0;
      while (!op_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_busy"}, 64'(n), 64'd33);
      check({tag, "_hi"}, hi, exp_hi_q.pop_front());
      check({tag, "_lo"}, lo, exp_lo_q.pop_front());
   endtask

   task automatic do_mt(input logic [3:0] o, input logic [31:0] d);
      @(negedge clk);
      op_valid = 1'b1; op = o; src0 = d;
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE;
   endtask

   initial begin
      logic [31:0] eh, el, a, b;
      logic [3:0]  o;
      int n;
      reset = 1'b1; op_valid = 1'b0; flush = 1'b0; op = MD_OP_NONE; src0 = '0; src1 = '0;
      #12;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_ready", op_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_rd", rd_data, 0);
      @(negedge clk);
      reset = 1'b0;

      run_md("mult_neg2x3", MD_OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_md("multu_max", MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_md("mult_m1m1", MD_OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
      run_md("div_m7_2", MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_md("div_ovf", MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
      run_md("divu_by0", MD_OP_DIVU, 32'd5, 32'd0, 32'h0, 32'h0);
      run_md("div_by0", MD_OP_DIV, 32'hFFFFFFF0, 32'd0, 32'h0, 32'h0);
      run_md("divu_100_7", MD_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      for (int i = 0; i < 6; i++) begin
         o = 4'($urandom_range(1, 4));
         a = $urandom;
         b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)) ^ {32{a[0]}};
         model(o, a, b, eh, el);
         run_md("rand", o, a, b, eh, el);
      end

      // MTHI then MFHI in the next cycle
      @(negedge clk);
      op_valid = 1'b1; op = MD_OP_MTHI; src0 = 32'h1234;
      @(negedge clk);
      op = MD_OP_MFHI;
      #1;
      check("mfhi_after_mthi", rd_data, 32'h1234);
      check("mfhi_stall", stall, 0);
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE;
      #1;
      check("rd_idle_zero", rd_data, 0);

      // Flush in IDLE blocks an MTHI
      @(negedge clk);
      op_valid = 1'b1; op = MD_OP_MTHI; src0 = 32'hDEAD; flush = 1'b1;
      #1;
      check("idle_flush_ready", op_ready, 0);
      check("idle_flush_stall", stall, 1);
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE; flush = 1'b0;
      #1;
      check("idle_flush_hi", hi, 32'h1234);

      // MFLO presented at T+5 of a DIV stalls until the result commits
      @(negedge clk);
      op_valid = 1'b1; op = MD_OP_DIV; src0 = 32'hFFFFFF9C; src1 = 32'd7;
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE;
      repeat (4) @(negedge clk);
      op_valid = 1'b1; op = MD_OP_MFLO;
      #1;
      n = 0;
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("mflo_stall_cycles", 64'(n), 64'd29);
      check("mflo_rd", rd_data, 32'hFFFFFFF2);
      check("mflo_hi", hi, 32'hFFFFFFFE);
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE;

      // Flush mid-multiply leaves HI/LO untouched
      do_mt(MD_OP_MTHI, 32'hAAAA);
      do_mt(MD_OP_MTLO, 32'h5555);
      @(negedge clk);
      op_valid = 1'b1; op = MD_OP_MULT; src0 = 32'd1000; src1 = 32'd1000;
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_mid_ready", op_ready, 1);
      check("flush_mid_hi", hi, 32'hAAAA);
      check("flush_mid_lo", lo, 32'h5555);

      // Flush during FIX suppresses the commit
      @(negedge clk);
      op_valid = 1'b1; op = MD_OP_MULT; src0 = 32'd1000; src1 = 32'd1000;
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE;
      repeat (32) @(negedge clk);
      check("fix_ready_low", op_ready, 0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_fix_ready", op_ready, 1);
      check("flush_fix_hi", hi, 32'hAAAA);
      check("flush_fix_lo", lo, 32'h5555);

      // Asynchronous reset mid-divide
      @(negedge clk);
      op_valid = 1'b1; op = MD_OP_DIV; src0 = 32'd12345; src1 = 32'd17;
      @(negedge clk);
      op_valid = 1'b0; op = MD_OP_NONE;
      repeat (19) @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("arst_hi", hi, 0);
      check("arst_lo", lo, 0);
      check("arst_ready", op_ready, 1);
      #1;
      reset = 1'b0;
      run_md("div_after_rst", MD_OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle HI/LO unit controller for the execute stage. It accepts one HI/LO operation at a time from the E-stage (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO) and sequences a radix-2 iterative multiplier/divider over 32 steps. It owns the HI and LO registers and tells the hazard unit when a HI/LO instruction must stall.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears all state.
- op_valid  in  1  E-stage presents a HI/LO operation this cycle.
- op  in  MD_OP_LEN  operation code, from the MD_OP_* constants.
- src0  in  32  rs value: multiplicand, dividend, or MTHI/MTLO data.
- src1  in  32  rt value: multiplier or divisor.
- flush  in  1  cancels the op in flight and blocks acceptance this cycle.
- op_ready  out  1  high iff the state is IDLE and flush is low.
- stall  out  1  op_valid && !op_ready.
- rd_data  out  32  HI for MFHI, LO for MFLO when accepted; 0 otherwise.
- hi, lo  out  32  architectural HI/LO registers.

## Operation
- Accept condition: op_valid && op_ready, evaluated at the rising edge.
- MTHI/MTLO: write src0 to HI/LO at the accept edge. State stays IDLE.
- MFHI/MFLO: rd_data is combinational from the HI/LO registers. No state change.
- MULT/MULTU/DIV/DIVU at accept:
  - Latch magnitudes of both operands. Signed ops take abs(); 0x80000000 stays 0x80000000 as an unsigned magnitude.
  - Latch the sign flags and the div-by-zero flag. Clear the 6-bit iteration counter cnt.
- States:
  - IDLE → MUL or DIV on acceptance of a mult/div op.
  - MUL/DIV → FIX when cnt==31.
  - FIX → IDLE, with commit.
  - Any state → IDLE on flush.
- MUL step: if the multiplier LSB is 1, add the multiplicand into the upper 33 bits of the 64-bit accumulator, then shift the accumulator right by 1.
- DIV step (restoring division): shift {rem, quo} left by 1, then trial-subtract the divisor. If the result is non-negative, keep it and set quo[0].
- FIX:
  - Signed MULT negates the 64-bit product when the operand signs differ.
  - Signed DIV negates the quotient when the signs differ; the remainder takes the dividend's sign.
  - Divisor 0: HI = LO = 0 regardless of signedness.
  - HI/LO are written only at the FIX→IDLE edge.
- Flush: synchronous. The next edge forces IDLE and HI/LO are not written, including when flush is high during FIX. In IDLE, flush blocks acceptance and MTHI/MTLO do not write.
- All arithmetic is modulo 2^64 for products and modulo 2^32 for quotient and remainder. The overflow case 0x80000000 / -1 gives LO = 0x80000000 and HI = 0.

## Timing
- Reset values: state IDLE, cnt 0, hi 0, lo 0, rd_data 0, op_ready 1 (while flush is 0), stall 0.
- For a mult/div accepted at the edge ending cycle T:
  - Cycles T+1 … T+32: iterations.
  - Cycle T+33: FIX.
  - Edge ending T+33: HI/LO commit.
  - Cycle T+34: op_ready = 1.
  - op_ready is low for exactly 33 cycles.
- MTHI accepted in cycle T: an MFHI in T+1 returns the new value. No bypass within the same cycle; an MFHI can't coexist with MTHI in one cycle anyway.
- A mult/div accepted back-to-back at the T+34 edge starts immediately; there are no idle bubbles.
- Reset asserted mid-operation clears HI/LO and returns to IDLE immediately, without waiting for a clock edge.

## Structure
- Add to the shared def.v:
  - MD_OP_LEN.
  - Op codes MD_OP_NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
  - MD_ST_* state encodings.
  - MD_ITERS = 32.
- Sub-module md_iter_step: combinational single-step datapath.
  - Inputs: mode, accumulator/remainder, operand.
  - Output: next value.
- md_sequencer keeps the FSM, counter, operand latches, FIX logic and HI/LO.
- The E-stage ALU's mult/div/MFHI/MFLO/MTHI/MTLO paths are removed. Its busy output is driven from stall.

## Test plan
- MULT src0=0xFFFFFFFE, src1=3 → op_ready low for 33 cycles; at T+34, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands → hi=0, lo=1.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → hi=lo=0 after 33 cycles.
- MTHI 0x1234 held across cycle T, then MFHI at T+1 → rd_data=0x1234. MFLO presented at T+5 of a DIV → stall=1 through T+33, accepted at T+34 with the committed LO.
- Preload hi=0xAAAA, lo=0x5555. Start MULT, flush at T+10 → op_ready=1 at T+11, hi/lo unchanged. Flush during FIX (T+33) → no commit.
- Assert reset asynchronously mid-DIV at T+20 → hi=lo=0 and op_ready=1 before the next clock edge. After release, a new DIV completes normally.
